uart_scarf_pkt: RTL and testbench

UART_SCARF_PKT -- requirements
Module: uart_scarf_pkt

---
 rtl/uart_scarf_pkt.sv | 180 ++++++++++++++++++
 tb/tb_uart_scarf_pkt.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_scarf_pkt.sv
// UART packet front end: decodes ID/address/data byte frames into bus write and read strobes,
// and streams read data back to the UART transmitter through a small return FIFO.
module uart_scarf_pkt #(
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ADDR_W = (ADDR_BYTES == 0) ? 1 : 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst_n_sync,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_inactive,
  input  logic              tx_bsy,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  output logic [6:0]        slave_id,
  output logic              rnw,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wr_data,
  output logic              wr_valid,
  output logic              rd_req,
  input  logic [7:0]        rd_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0] LAST_ADDR_IDX = (ADDR_BYTES == 0) ? 3'd0 : 3'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle, StId, StAddr, StWdata, StRcnt, StRissue, StFlush
  } state_e;

  state_e           state_q;
  logic             rx_inactive_q;
  logic [2:0]       addr_idx_q;
  logic [8:0]       rd_cnt_q;
  logic             rd_pend_q;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  logic             rx_fall;
  logic             rx_rise;
  logic             fifo_push;
  logic             fifo_pop;
  logic             can_issue;
  logic [CNT_W:0]   committed;

  assign rx_fall = rx_inactive_q & ~rx_inactive;
  assign rx_rise = ~rx_inactive_q & rx_inactive;

  // Slots already spoken for: stored entries, the read on the bus now, and the one landing now.
  assign committed = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, rd_req} + {{CNT_W{1'b0}}, rd_pend_q};
  assign can_issue = committed < {1'b0, DEPTH_C};

  assign fifo_push = rd_pend_q;
  assign tx_send   = (fifo_cnt_q != '0);
  assign fifo_pop  = tx_send & ~tx_bsy;
  assign tx_data   = tx_send ? fifo_mem[rd_ptr_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= StIdle;
      rx_inactive_q <= 1'b1;
      addr_idx_q    <= '0;
      rd_cnt_q      <= '0;
      rd_pend_q     <= 1'b0;
      slave_id      <= '0;
      rnw           <= 1'b0;
      addr          <= '0;
      wr_data       <= '0;
      wr_valid      <= 1'b0;
      rd_req        <= 1'b0;
      frame_done    <= 1'b1;
      frame_err     <= 1'b0;
    end else begin
      rx_inactive_q <= rx_inactive;
      wr_valid      <= 1'b0;
      rd_req        <= 1'b0;
      frame_err     <= 1'b0;
      rd_pend_q     <= rd_req;
      // Post-increment after every bus strobe; ID/ADDR decoding below overrides it.
      if (wr_valid || rd_req) addr <= addr + ADDR_W'(1);

      unique case (state_q)
        StIdle: begin
          if (rx_fall) begin
            state_q    <= StId;
            frame_done <= 1'b0;
          end
        end
        StId: begin
          if (rx_rise) begin
            state_q    <= StIdle;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
          end else if (rx_valid) begin
            slave_id   <= rx_data[6:0];
            rnw        <= rx_data[7];
            addr       <= '0;
            addr_idx_q <= '0;
            if (ADDR_BYTES > 0) state_q <= StAddr;
            else                state_q <= rx_data[7] ? StRcnt : StWdata;
          end
        end
        StAddr: begin
          if (rx_rise) begin
            state_q    <= StIdle;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
          end else if (rx_valid) begin
            addr       <= ADDR_W'({addr, rx_data});
            addr_idx_q <= addr_idx_q + 3'd1;
            if (addr_idx_q == LAST_ADDR_IDX) state_q <= rnw ? StRcnt : StWdata;
          end
        end
        StWdata: begin
          if (rx_rise) begin
            state_q    <= StIdle;
            frame_done <= 1'b1;
          end else if (rx_valid) begin
            wr_data  <= rx_data;
            wr_valid <= 1'b1;
          end
        end
        StRcnt: begin
          if (rx_rise) begin
            state_q    <= StIdle;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
          end else if (rx_valid) begin
            // A count byte of zero requests 256 reads.
            rd_cnt_q <= {rx_data == 8'd0, rx_data};
            state_q  <= StRissue;
          end
        end
        StRissue: begin
          if (can_issue) begin
            rd_req   <= 1'b1;
            rd_cnt_q <= rd_cnt_q - 9'd1;
            if (rd_cnt_q == 9'd1) state_q <= StFlush;
          end
        end
        StFlush: begin
          if ((fifo_cnt_q == '0) && !rd_req && !rd_pend_q && !tx_bsy) begin
            state_q    <= StIdle;
            frame_done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_scarf_pkt.sv
// Directed bench for uart_scarf_pkt: instance a uses an 8-entry FIFO, instance b a 2-entry FIFO;
// both share the UART-side stimulus and each has its own read-data responder.
module tb_uart_scarf_pkt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_sync;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_inactive;
  logic       tx_bsy;

  logic [7:0] tx_data_a, tx_data_b, addr_a, addr_b, wr_data_a, wr_data_b;
  logic [7:0] rd_data_a = 8'h00;
  logic [7:0] rd_data_b = 8'h00;
  logic [6:0] slave_id_a, slave_id_b;
  logic       tx_send_a, tx_send_b, rnw_a, rnw_b, wr_valid_a, wr_valid_b;
  logic       rd_req_a, rd_req_b, frame_done_a, frame_done_b, frame_err_a, frame_err_b;

  uart_scarf_pkt #(.ADDR_BYTES(1), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n_sync(rst_n_sync), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_inactive(rx_inactive), .tx_bsy(tx_bsy), .tx_data(tx_data_a), .tx_send(tx_send_a),
    .slave_id(slave_id_a), .rnw(rnw_a), .addr(addr_a), .wr_data(wr_data_a),
    .wr_valid(wr_valid_a), .rd_req(rd_req_a), .rd_data(rd_data_a),
    .frame_done(frame_done_a), .frame_err(frame_err_a)
  );

  uart_scarf_pkt #(.ADDR_BYTES(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n_sync(rst_n_sync), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_inactive(rx_inactive), .tx_bsy(tx_bsy), .tx_data(tx_data_b), .tx_send(tx_send_b),
    .slave_id(slave_id_b), .rnw(rnw_b), .addr(addr_b), .wr_data(wr_data_b),
    .wr_valid(wr_valid_b), .rd_req(rd_req_b), .rd_data(rd_data_b),
    .frame_done(frame_done_b), .frame_err(frame_err_b)
  );

  // Bus slave model: read data is address + 1, returned one cycle after the request.
  always @(posedge clk) begin
    if (rd_req_a) rd_data_a <= addr_a + 8'd1;
    if (rd_req_b) rd_data_b <= addr_b + 8'd1;
  end

  logic [15:0] wr_log_a[$];
  logic [7:0]  rd_log_a[$], tx_log_a[$], rd_log_b[$], tx_log_b[$];
  int          err_n_a = 0;
  int          both_n  = 0;

  always @(negedge clk) begin
    if (wr_valid_a) wr_log_a.push_back({addr_a, wr_data_a});
    if (rd_req_a) rd_log_a.push_back(addr_a);
    if (rd_req_b) rd_log_b.push_back(addr_b);
    if (tx_send_a && !tx_bsy) tx_log_a.push_back(tx_data_a);
    if (tx_send_b && !tx_bsy) tx_log_b.push_back(tx_data_b);
    if (frame_err_a) err_n_a++;
    if ((wr_valid_a && rd_req_a) || (wr_valid_b && rd_req_b)) both_n++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(3);
  endtask

  task automatic frame_start();
    rx_inactive = 1'b0;
    cyc(2);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (!(frame_done_a && frame_done_b) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    check(tag, {31'd0, frame_done_a && frame_done_b}, 32'd1);
  endtask

  int wb, rb, tb_a, rb_b, tb_b, eb;

  initial begin
    rst_n_sync  = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    rx_inactive = 1'b1;
    tx_bsy      = 1'b0;
    cyc(3);
    check("rst frame_done", {31'd0, frame_done_a}, 32'd1);
    check("rst frame_err", {31'd0, frame_err_a}, 32'd0);
    check("rst tx_send", {31'd0, tx_send_a}, 32'd0);
    check("rst tx_data", {24'd0, tx_data_a}, 32'h00);
    check("rst addr/id/rnw", {16'd0, addr_a, rnw_a, slave_id_a}, 32'd0);
    check("rst strobes", {30'd0, wr_valid_a, rd_req_a}, 32'd0);
    rst_n_sync = 1'b1;
    cyc(2);

    // Write frame
    wb = wr_log_a.size();
    frame_start();
    check("frame_done busy", {31'd0, frame_done_a}, 32'd0);
    send_byte(8'h05); send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB);
    rx_inactive = 1'b1;
    wait_idle("wr idle", 20);
    check("wr slave_id/rnw", {24'd0, rnw_a, slave_id_a}, 32'h05);
    check("wr count", wr_log_a.size() - wb, 2);
    if (wr_log_a.size() - wb == 2) begin
      check("wr0 addr/data", {16'd0, wr_log_a[wb]}, 32'h10AA);
      check("wr1 addr/data", {16'd0, wr_log_a[wb+1]}, 32'h11BB);
    end

    // Read frame, count 3
    rb = rd_log_a.size(); tb_a = tx_log_a.size();
    frame_start();
    send_byte(8'h83); send_byte(8'h20); send_byte(8'h03);
    rx_inactive = 1'b1;
    wait_idle("rd idle", 200);
    check("rd slave_id/rnw", {24'd0, rnw_a, slave_id_a}, 32'h83);
    check("rd count", rd_log_a.size() - rb, 3);
    check("rd tx count", tx_log_a.size() - tb_a, 3);
    if (rd_log_a.size() - rb == 3 && tx_log_a.size() - tb_a == 3) begin
      check("rd addrs", {8'd0, rd_log_a[rb], rd_log_a[rb+1], rd_log_a[rb+2]}, 32'h202122);
      check("rd tx bytes", {8'd0, tx_log_a[tb_a], tx_log_a[tb_a+1], tx_log_a[tb_a+2]},
            32'h212223);
    end

    // Abort before the address byte
    wb = wr_log_a.size(); rb = rd_log_a.size(); eb = err_n_a;
    frame_start();
    send_byte(8'h01);
    rx_inactive = 1'b1;
    wait_idle("abort idle", 20);
    cyc(2);
    check("abort err pulses", err_n_a - eb, 1);
    check("abort no strobes", (wr_log_a.size() - wb) + (rd_log_a.size() - rb), 0);
    check("abort frame_done", {31'd0, frame_done_a}, 32'd1);

    // Zero count = 256 reads, address wraps
    rb = rd_log_a.size(); tb_a = tx_log_a.size(); rb_b = rd_log_b.size();
    frame_start();
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'h00);
    rx_inactive = 1'b1;
    wait_idle("wrap idle", 3000);
    check("wrap rd count a", rd_log_a.size() - rb, 256);
    check("wrap rd count b", rd_log_b.size() - rb_b, 256);
    check("wrap tx count a", tx_log_a.size() - tb_a, 256);
    if (rd_log_a.size() - rb == 256 && tx_log_a.size() - tb_a == 256) begin
      check("wrap addrs", {8'd0, rd_log_a[rb], rd_log_a[rb+1], rd_log_a[rb+255]}, 32'hFF00FE);
      check("wrap tx first/last", {16'd0, tx_log_a[tb_a], tx_log_a[tb_a+255]}, 32'h00FF);
    end
    check("wrap final addr", {24'd0, addr_a}, 32'hFF);

    // Backpressure on the 2-entry instance
    rb_b = rd_log_b.size(); tb_b = tx_log_b.size();
    tx_bsy = 1'b1;
    frame_start();
    send_byte(8'h81); send_byte(8'h40); send_byte(8'h05);
    rx_inactive = 1'b1;
    cyc(100);
    check("bp rd held", rd_log_b.size() - rb_b, 2);
    check("bp tx held", tx_log_b.size() - tb_b, 0);
    check("bp tx_send", {31'd0, tx_send_b}, 32'd1);
    tx_bsy = 1'b0;
    wait_idle("bp idle", 300);
    check("bp rd total", rd_log_b.size() - rb_b, 5);
    check("bp tx total", tx_log_b.size() - tb_b, 5);
    if (tx_log_b.size() - tb_b == 5) begin
      check("bp tx bytes", {tx_log_b[tb_b], tx_log_b[tb_b+1], tx_log_b[tb_b+2],
                            tx_log_b[tb_b+3]}, 32'h41424344);
      check("bp tx last", {24'd0, tx_log_b[tb_b+4]}, 32'h45);
    end

    // Reset while reads are stalled with data queued
    rb = rd_log_a.size();
    tx_bsy = 1'b1;
    frame_start();
    send_byte(8'h81); send_byte(8'h50); send_byte(8'h0A);
    for (int i = 0; i < 200 && rd_log_a.size() - rb < 5; i++) cyc(1);
    check("mid rd issued", {31'd0, rd_log_a.size() - rb >= 5}, 32'd1);
    check("mid tx_send", {31'd0, tx_send_a}, 32'd1);
    rst_n_sync  = 1'b0;
    rx_inactive = 1'b1;
    #1;
    check("mid rst tx", {23'd0, tx_send_a, tx_data_a}, 32'd0);
    check("mid rst state", {14'd0, frame_done_a, frame_err_a, addr_a, rnw_a, slave_id_a},
          32'h20000);
    check("mid rst strobes", {30'd0, wr_valid_a, rd_req_a}, 32'd0);
    cyc(2);
    rst_n_sync = 1'b1;
    tx_bsy     = 1'b0;
    tb_a = tx_log_a.size(); wb = wr_log_a.size();
    cyc(1);
    check("post rst strobes", {29'd0, wr_valid_a, rd_req_a, tx_send_a}, 32'd0);
    frame_start();
    send_byte(8'h07); send_byte(8'h30); send_byte(8'h55);
    rx_inactive = 1'b1;
    wait_idle("post rst idle", 20);
    check("post rst id", {24'd0, rnw_a, slave_id_a}, 32'h07);
    check("post rst wr count", wr_log_a.size() - wb, 1);
    if (wr_log_a.size() - wb == 1) check("post rst wr", {16'd0, wr_log_a[wb]}, 32'h3055);
    check("post rst no stale tx", tx_log_a.size() - tb_a, 0);
    check("wr/rd never together", both_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
